// File: rtl/cv32e40p_fault_handler.sv
// Single sink for the TMR voter fault flags: sticky status, saturating per-unit
// counters, one flush/replay request per episode and fatal escalation on repeat.
module cv32e40p_fault_handler #(
    parameter int unsigned NUNITS = 4,
    parameter int unsigned CNT_W  = 8,
    parameter int unsigned WINDOW = 16,
    localparam int unsigned SEL_W = (NUNITS > 1) ? $clog2(NUNITS) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUNITS-1:0] fault_i,
    input  logic [NUNITS-1:0] mask_i,
    input  logic              retry_ack_i,
    input  logic              clear_i,
    input  logic [SEL_W-1:0]  cnt_sel_i,
    output logic              retry_req_o,
    output logic [NUNITS-1:0] fault_unit_o,
    output logic [NUNITS-1:0] sticky_o,
    output logic [CNT_W-1:0]  cnt_o,
    output logic              fatal_o
);

    localparam int unsigned TIMER_W = 8;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_REQ    = 2'd1,
        S_WINDOW = 2'd2,
        S_FATAL  = 2'd3
    } state_e;

    state_e              state_q, state_d;
    logic [NUNITS-1:0]   cause_q, cause_d;
    logic [TIMER_W-1:0]  timer_q, timer_d;
    logic [NUNITS-1:0]   sticky_q, sticky_d;
    logic [CNT_W-1:0]    cnt_q [NUNITS];
    logic [CNT_W-1:0]    cnt_d [NUNITS];
    logic                retry_req_q, retry_req_d;
    logic                fatal_q, fatal_d;
    logic [NUNITS-1:0]   f;

    assign f = fault_i & ~mask_i;

    // Sticky status and saturating counters run in every state, FATAL included.
    always_comb begin
        sticky_d = clear_i ? f : (sticky_q | f);
        for (int i = 0; i < NUNITS; i++) begin
            cnt_d[i] = cnt_q[i];
            if (clear_i) begin
                cnt_d[i] = CNT_W'(f[i]);
            end else if (f[i] && (cnt_q[i] != {CNT_W{1'b1}})) begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end
    end

    // Episode FSM: a repeat fault on an already-replayed unit inside the window is fatal.
    always_comb begin
        state_d = state_q;
        cause_d = cause_q;
        timer_d = timer_q;
        case (state_q)
            S_IDLE: begin
                if (f != '0) begin
                    state_d = S_REQ;
                    cause_d = f;
                end
            end
            S_REQ: begin
                cause_d = cause_q | f;
                if (retry_ack_i) begin
                    state_d = S_WINDOW;
                    timer_d = TIMER_W'(WINDOW);
                end
            end
            S_WINDOW: begin
                timer_d = timer_q - TIMER_W'(1);
                if ((f & cause_q) != '0) begin
                    state_d = S_FATAL;
                    timer_d = '0;
                end else if (f != '0) begin
                    state_d = S_REQ;
                    cause_d = f;
                    timer_d = '0;
                end else if (timer_q == TIMER_W'(1)) begin
                    state_d = S_IDLE;
                    cause_d = '0;
                end
            end
            S_FATAL: begin
                state_d = S_FATAL;
            end
            default: begin
                state_d = S_IDLE;
                cause_d = '0;
                timer_d = '0;
            end
        endcase
        retry_req_d = (state_d == S_REQ);
        fatal_d     = (state_d == S_FATAL);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cause_q     <= '0;
            timer_q     <= '0;
            sticky_q    <= '0;
            retry_req_q <= 1'b0;
            fatal_q     <= 1'b0;
            for (int i = 0; i < NUNITS; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            cause_q     <= cause_d;
            timer_q     <= timer_d;
            sticky_q    <= sticky_d;
            retry_req_q <= retry_req_d;
            fatal_q     <= fatal_d;
            for (int i = 0; i < NUNITS; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // Read mux; selects beyond the last unit read as zero.
    always_comb begin
        cnt_o = '0;
        if (32'(cnt_sel_i) < NUNITS) begin
            cnt_o = cnt_q[cnt_sel_i];
        end
    end

    assign retry_req_o  = retry_req_q;
    assign fatal_o      = fatal_q;
    assign fault_unit_o = cause_q;
    assign sticky_o     = sticky_q;

endmodule
